dmem_responder: RTL

- Data-memory responder for the 64-bit pipeline's MEM stage.
- The pipeline is the initiator and issues load/store requests over a valid/ready request channel; this block services them with a fixed latency and returns results over a valid/ready response channel.
- Holds a doubleword-organised little-endian RAM, performs byte-lane alignment on stores, and does lane extraction plus sign/zero extension on loads.

---
 rtl/dmem_pkg.sv | 39 +++
 rtl/dmem_lane_align.sv | 52 +++++
 rtl/dmem_responder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Encodes access sizes, FSM states and the lane-offset alignment rules.
package dmem_pkg;

  localparam int OFF_W = 3;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  // Lane offset rounded down to the natural alignment of the access size.
  function automatic logic [OFF_W-1:0] align_off(input logic [1:0] size,
                                                 input logic [OFF_W-1:0] off);
    logic [OFF_W-1:0] res;
    case (size)
      SZ_B:    res = off;
      SZ_H:    res = {off[2:1], 1'b0};
      SZ_W:    res = {off[2], 2'b00};
      SZ_D:    res = 3'b000;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [OFF_W-1:0] off);
    return (off != align_off(size, off));
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store-side byte enables and shifted data,
// load-side lane extraction with sign/zero extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]       size,
  input  logic [OFF_W-1:0] offset,
  input  logic [63:0]      wdata,
  input  logic [63:0]      rword,
  input  logic             is_unsigned,
  output logic [7:0]       byte_en,
  output logic [63:0]      wdata_sh,
  output logic [63:0]      rdata
);

  logic [OFF_W-1:0] aoff_s;
  logic [5:0]       shamt_s;
  logic [63:0]      rsh_s;

  // Lane steering for both directions from the aligned offset.
  always_comb begin
    aoff_s   = align_off(size, offset);
    shamt_s  = {aoff_s, 3'b000};
    wdata_sh = wdata << shamt_s;
    rsh_s    = rword >> shamt_s;
    byte_en  = 8'h00;
    rdata    = 64'h0;
    case (size)
      SZ_B: begin
        byte_en = 8'h01 << aoff_s;
        rdata   = is_unsigned ? {56'h0, rsh_s[7:0]} : {{56{rsh_s[7]}}, rsh_s[7:0]};
      end
      SZ_H: begin
        byte_en = 8'h03 << aoff_s;
        rdata   = is_unsigned ? {48'h0, rsh_s[15:0]} : {{48{rsh_s[15]}}, rsh_s[15:0]};
      end
      SZ_W: begin
        byte_en = 8'h0F << aoff_s;
        rdata   = is_unsigned ? {32'h0, rsh_s[31:0]} : {{32{rsh_s[31]}}, rsh_s[31:0]};
      end
      SZ_D: begin
        byte_en = 8'hFF;
        rdata   = rsh_s;
      end
      default: begin
        byte_en = 8'h00;
        rdata   = 64'h0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency load/store responder with a little-endian doubleword RAM.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned accesses as faults.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e      state_r, state_n;
  logic [3:0]  cnt_r, cnt_n;
  logic        accept_s;
  logic        ready_r, rsp_valid_r, rsp_err_r;
  logic [63:0] rsp_rdata_r;

  logic [63:0] mem_r [DEPTH_WORDS];
  logic [AW-1:0] idx_s;
  logic        oor_s, fault_s;
  logic [7:0]  byte_en_s;
  logic [63:0] wdata_sh_s, rword_s, ldata_s;

  assign idx_s   = req_addr[OFF_W +: AW];
  assign oor_s   = |req_addr[63:OFF_W+AW];
  assign rword_s = mem_r[idx_s];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign fault_s = oor_s | is_misaligned(req_size, req_addr[OFF_W-1:0]);
`else
  assign fault_s = oor_s;
`endif

  dmem_lane_align u_align (
    .size        (req_size),
    .offset      (req_addr[OFF_W-1:0]),
    .wdata       (req_wdata),
    .rword       (rword_s),
    .is_unsigned (req_unsigned),
    .byte_en     (byte_en_s),
    .wdata_sh    (wdata_sh_s),
    .rdata       (ldata_s)
  );

  // Next-state and latency counter; BUSY is skipped when LATENCY is 1.
  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid && ready_r) begin
          accept_s = 1'b1;
          cnt_n    = CNT_INIT;
          if (LATENCY == 1) begin
            state_n = RESP;
          end else begin
            state_n = BUSY;
          end
        end else begin
          state_n = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == 4'd0) begin
          state_n = RESP;
        end else begin
          cnt_n = cnt_r - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_n = IDLE;
        end else begin
          state_n = RESP;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state and registered handshake/response outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      ready_r     <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 64'h0;
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      ready_r     <= (state_n == IDLE);
      rsp_valid_r <= (state_n == RESP);
      if (accept_s) begin
        rsp_err_r   <= fault_s;
        rsp_rdata_r <= (fault_s || req_write) ? 64'h0 : ldata_s;
      end else if (state_r == RESP && rsp_ready) begin
        rsp_err_r   <= 1'b0;
        rsp_rdata_r <= 64'h0;
      end
    end
  end

  // Store commit on the accept edge; RAM contents survive reset.
  always_ff @(posedge clock) begin
    if (accept_s && req_write && !fault_s && !reset) begin
      for (int i = 0; i < 8; i++) begin
        if (byte_en_s[i]) begin
          mem_r[idx_s][8*i +: 8] <= wdata_sh_s[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule
